// File: rtl/sram_seq_pkg.sv
// Shared types and helpers for the SRAM phase sequencer.
// The optional second processing phase is enabled by defining M2_PHASE_EN.
package sram_seq_pkg;

  localparam int ADDR_W  = 18;
  localparam int DATA_W  = 16;
  localparam int TIMER_W = 26;
  localparam int GAP_W   = 4;

  localparam logic [2:0] PHASE_IDLE = 3'd0;
  localparam logic [2:0] PHASE_UART = 3'd1;
  localparam logic [2:0] PHASE_GAP  = 3'd2;
  localparam logic [2:0] PHASE_M1   = 3'd3;
  localparam logic [2:0] PHASE_M2   = 3'd4;
  localparam logic [2:0] PHASE_VGA  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UART_ARM,
    S_UART_RX,
    S_GAP,
    S_M1,
`ifdef M2_PHASE_EN
    S_M2,
`endif
    S_VGA
  } seq_state_type;

  typedef enum logic [2:0] {
    OWNER_NONE,
    OWNER_UART,
    OWNER_M1,
`ifdef M2_PHASE_EN
    OWNER_M2,
`endif
    OWNER_VGA
  } sram_owner_type;

  // Which unit owns the SRAM port while the FSM sits in a given phase.
  function automatic sram_owner_type owner_of(input seq_state_type s);
    case (s)
      S_UART_ARM, S_UART_RX: return OWNER_UART;
      S_M1:                  return OWNER_M1;
`ifdef M2_PHASE_EN
      S_M2:                  return OWNER_M2;
`endif
      S_VGA:                 return OWNER_VGA;
      default:               return OWNER_NONE;
    endcase
  endfunction

  function automatic logic [2:0] phase_of(input seq_state_type s);
    case (s)
      S_UART_ARM, S_UART_RX: return PHASE_UART;
      S_GAP:                 return PHASE_GAP;
      S_M1:                  return PHASE_M1;
`ifdef M2_PHASE_EN
      S_M2:                  return PHASE_M2;
`endif
      S_VGA:                 return PHASE_VGA;
      default:               return PHASE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sram_owner_mux.sv
// Combinational owner-select of the shared SRAM controller port.
// M2 inputs exist only when M2_PHASE_EN is defined.
module sram_owner_mux
  import sram_seq_pkg::*;
(
  input  sram_owner_type    owner_i,
  input  logic              block_i,
  input  logic [ADDR_W-1:0] hold_addr_i,
  input  logic [ADDR_W-1:0] uart_addr_i,
  input  logic [DATA_W-1:0] uart_data_i,
  input  logic              uart_we_n_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  input  logic              m1_we_n_i,
`ifdef M2_PHASE_EN
  input  logic [ADDR_W-1:0] m2_addr_i,
  input  logic [DATA_W-1:0] m2_data_i,
  input  logic              m2_we_n_i,
`endif
  input  logic [ADDR_W-1:0] vga_addr_i,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_data_o,
  output logic              sram_we_n_o
);

  // With no live owner the address parks on the last value and writes stay off.
  always_comb begin
    sram_addr_o = hold_addr_i;
    sram_data_o = '0;
    sram_we_n_o = 1'b1;
    if (!block_i) begin
      case (owner_i)
        OWNER_UART: begin
          sram_addr_o = uart_addr_i;
          sram_data_o = uart_data_i;
          sram_we_n_o = uart_we_n_i;
        end
        OWNER_M1: begin
          sram_addr_o = m1_addr_i;
          sram_data_o = m1_data_i;
          sram_we_n_o = m1_we_n_i;
        end
`ifdef M2_PHASE_EN
        OWNER_M2: begin
          sram_addr_o = m2_addr_i;
          sram_data_o = m2_data_i;
          sram_we_n_o = m2_we_n_i;
        end
`endif
        OWNER_VGA: begin
          sram_addr_o = vga_addr_i;
        end
        default: begin
          sram_addr_o = hold_addr_i;
        end
      endcase
    end
  end

endmodule

// File: rtl/sram_phase_sequencer.sv
// Image-flow sequencer: UART load -> M1 (-> M2 with M2_PHASE_EN) -> VGA,
// sole owner of the SRAM controller port with a write-blocked gap at each handover.
module sram_phase_sequencer
  import sram_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int GAP_CYCLES     = 2
) (
  input  logic              CLOCK_50_I,
  input  logic              Resetn,
  input  logic              Start_pulse,
  input  logic              UART_RX_I,
  output logic              UART_rx_initialize,
  output logic              UART_rx_enable,
  input  logic [ADDR_W-1:0] UART_SRAM_address,
  input  logic [DATA_W-1:0] UART_SRAM_write_data,
  input  logic              UART_SRAM_we_n,
  output logic              M1_start,
  input  logic              M1_done,
  input  logic [ADDR_W-1:0] M1_SRAM_address,
  input  logic [DATA_W-1:0] M1_SRAM_write_data,
  input  logic              M1_SRAM_we_n,
`ifdef M2_PHASE_EN
  output logic              M2_start,
  input  logic              M2_done,
  input  logic [ADDR_W-1:0] M2_SRAM_address,
  input  logic [DATA_W-1:0] M2_SRAM_write_data,
  input  logic              M2_SRAM_we_n,
`endif
  output logic              VGA_enable,
  input  logic [ADDR_W-1:0] VGA_SRAM_address,
  output logic [ADDR_W-1:0] SRAM_address,
  output logic [DATA_W-1:0] SRAM_write_data,
  output logic              SRAM_we_n,
  output logic [2:0]        Phase
);

  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST     = GAP_W'(GAP_CYCLES - 1);

  seq_state_type     state_q, state_d;
  seq_state_type     target_q, target_d;
  sram_owner_type    owner_q, owner_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;

  logic          timeout_hit;
  logic          enter_gap;
  seq_state_type gap_to;

  // An address of 0 means nothing has been received yet, so never time out.
  assign timeout_hit = (timer_q == TIMEOUT_LAST) && (UART_SRAM_address != '0);

  always_comb begin
    state_d            = state_q;
    target_d           = target_q;
    owner_d            = owner_q;
    gap_cnt_d          = gap_cnt_q;
    timer_d            = '0;
    UART_rx_initialize = 1'b0;
    UART_rx_enable     = 1'b0;
    enter_gap          = 1'b0;
    gap_to             = target_q;
    case (state_q)
      S_IDLE: begin
        if (Start_pulse || !UART_RX_I) begin
          UART_rx_initialize = 1'b1;
          state_d            = S_UART_ARM;
          owner_d            = OWNER_UART;
        end
      end
      S_UART_ARM: begin
        UART_rx_enable = 1'b1;
        state_d        = S_UART_RX;
      end
      S_UART_RX: begin
        if (timeout_hit) begin
          UART_rx_initialize = 1'b1;
          enter_gap          = 1'b1;
          gap_to             = S_M1;
        end else begin
          UART_rx_enable = 1'b1;
          if (!UART_SRAM_we_n) begin
            timer_d = '0;
          end else if (timer_q != TIMEOUT_LAST) begin
            timer_d = timer_q + 1'b1;
          end else begin
            timer_d = timer_q;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = target_q;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      S_M1: begin
        if (M1_done) begin
          enter_gap = 1'b1;
`ifdef M2_PHASE_EN
          gap_to    = S_M2;
`else
          gap_to    = S_VGA;
`endif
        end
      end
`ifdef M2_PHASE_EN
      S_M2: begin
        if (M2_done) begin
          enter_gap = 1'b1;
          gap_to    = S_VGA;
        end
      end
`endif
      S_VGA: begin
        if (Start_pulse) begin
          UART_rx_initialize = 1'b1;
          enter_gap          = 1'b1;
          gap_to             = S_UART_ARM;
        end
      end
      default: begin
        state_d = S_IDLE;
        owner_d = OWNER_NONE;
      end
    endcase
    // The owner register is retargeted once, on gap entry; the gap itself blocks writes.
    if (enter_gap) begin
      state_d   = S_GAP;
      target_d  = gap_to;
      owner_d   = owner_of(gap_to);
      gap_cnt_d = '0;
    end
  end

  assign hold_addr_d = ((state_q != S_GAP) && (owner_q != OWNER_NONE)) ? SRAM_address
                                                                      : hold_addr_q;

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= S_IDLE;
      target_q    <= S_IDLE;
      owner_q     <= OWNER_NONE;
      gap_cnt_q   <= '0;
      timer_q     <= '0;
      hold_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      owner_q     <= owner_d;
      gap_cnt_q   <= gap_cnt_d;
      timer_q     <= timer_d;
      hold_addr_q <= hold_addr_d;
    end
  end

  assign M1_start   = (state_q == S_M1);
`ifdef M2_PHASE_EN
  assign M2_start   = (state_q == S_M2);
`endif
  assign VGA_enable = (state_q == S_VGA);
  assign Phase      = phase_of(state_q);

  sram_owner_mux u_owner_mux (
    .owner_i     (owner_q),
    .block_i     (state_q == S_GAP),
    .hold_addr_i (hold_addr_q),
    .uart_addr_i (UART_SRAM_address),
    .uart_data_i (UART_SRAM_write_data),
    .uart_we_n_i (UART_SRAM_we_n),
    .m1_addr_i   (M1_SRAM_address),
    .m1_data_i   (M1_SRAM_write_data),
    .m1_we_n_i   (M1_SRAM_we_n),
`ifdef M2_PHASE_EN
    .m2_addr_i   (M2_SRAM_address),
    .m2_data_i   (M2_SRAM_write_data),
    .m2_we_n_i   (M2_SRAM_we_n),
`endif
    .vga_addr_i  (VGA_SRAM_address),
    .sram_addr_o (SRAM_address),
    .sram_data_o (SRAM_write_data),
    .sram_we_n_o (SRAM_we_n)
  );

endmodule

// File: tb/tb_sram_phase_sequencer.sv
// Directed bench for sram_phase_sequencer with a phase-level reference model.
// Builds with or without M2_PHASE_EN.
module tb_sram_phase_sequencer;

  localparam int TIMEOUT = 1000;
  localparam int GAP     = 2;

  logic        clk;
  logic        Resetn = 1'b0;
  logic        Start_pulse = 1'b0;
  logic        UART_RX_I = 1'b1;
  logic        UART_rx_initialize, UART_rx_enable;
  logic [17:0] UART_SRAM_address = '0;
  logic [15:0] UART_SRAM_write_data = '0;
  logic        UART_SRAM_we_n = 1'b1;
  logic        M1_start;
  logic        M1_done = 1'b0;
  logic [17:0] M1_SRAM_address = '0;
  logic [15:0] M1_SRAM_write_data = '0;
  logic        M1_SRAM_we_n = 1'b1;
`ifdef M2_PHASE_EN
  logic        M2_start;
  logic        M2_done = 1'b0;
  logic [17:0] M2_SRAM_address = '0;
  logic [15:0] M2_SRAM_write_data = '0;
  logic        M2_SRAM_we_n = 1'b1;
`endif
  logic        VGA_enable;
  logic [17:0] VGA_SRAM_address = '0;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic [2:0]  Phase;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  sram_phase_sequencer #(.TIMEOUT_CYCLES(TIMEOUT), .GAP_CYCLES(GAP)) dut (
    .CLOCK_50_I           (clk),
    .Resetn               (Resetn),
    .Start_pulse          (Start_pulse),
    .UART_RX_I            (UART_RX_I),
    .UART_rx_initialize   (UART_rx_initialize),
    .UART_rx_enable       (UART_rx_enable),
    .UART_SRAM_address    (UART_SRAM_address),
    .UART_SRAM_write_data (UART_SRAM_write_data),
    .UART_SRAM_we_n       (UART_SRAM_we_n),
    .M1_start             (M1_start),
    .M1_done              (M1_done),
    .M1_SRAM_address      (M1_SRAM_address),
    .M1_SRAM_write_data   (M1_SRAM_write_data),
    .M1_SRAM_we_n         (M1_SRAM_we_n),
`ifdef M2_PHASE_EN
    .M2_start             (M2_start),
    .M2_done              (M2_done),
    .M2_SRAM_address      (M2_SRAM_address),
    .M2_SRAM_write_data   (M2_SRAM_write_data),
    .M2_SRAM_we_n         (M2_SRAM_we_n),
`endif
    .VGA_enable           (VGA_enable),
    .VGA_SRAM_address     (VGA_SRAM_address),
    .SRAM_address         (SRAM_address),
    .SRAM_write_data      (SRAM_write_data),
    .SRAM_we_n            (SRAM_we_n),
    .Phase                (Phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- phase-level reference model ----------------
  // Phase number alone decides who drives the SRAM; only idle/gap use the parked address.
  int          m_phase = 0;
  bit          m_arm = 1'b0;
  int          m_idle = 0;
  int          m_gap_left = 0;
  int          m_gap_next = 0;
  logic [17:0] m_hold = '0;

  function automatic logic [17:0] m_addr();
    case (m_phase)
      1: return UART_SRAM_address;
      3: return M1_SRAM_address;
`ifdef M2_PHASE_EN
      4: return M2_SRAM_address;
`endif
      5: return VGA_SRAM_address;
      default: return m_hold;
    endcase
  endfunction

  function automatic logic [15:0] m_data();
    case (m_phase)
      1: return UART_SRAM_write_data;
      3: return M1_SRAM_write_data;
`ifdef M2_PHASE_EN
      4: return M2_SRAM_write_data;
`endif
      default: return 16'h0;
    endcase
  endfunction

  function automatic logic m_we_n();
    case (m_phase)
      1: return UART_SRAM_we_n;
      3: return M1_SRAM_we_n;
`ifdef M2_PHASE_EN
      4: return M2_SRAM_we_n;
`endif
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic m_timeout();
    return (m_phase == 1) && !m_arm && (m_idle >= TIMEOUT - 1) && (UART_SRAM_address != 18'd0);
  endfunction

  function automatic logic m_init();
    return ((m_phase == 0) && (Start_pulse || !UART_RX_I)) ||
           ((m_phase == 5) && Start_pulse) || m_timeout();
  endfunction

  always @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      m_phase    <= 0;
      m_arm      <= 1'b0;
      m_idle     <= 0;
      m_gap_left <= 0;
      m_gap_next <= 0;
      m_hold     <= '0;
    end else begin
      if (m_phase == 1 || m_phase == 3 || m_phase == 4 || m_phase == 5) m_hold <= m_addr();
      case (m_phase)
        0: if (Start_pulse || !UART_RX_I) begin m_phase <= 1; m_arm <= 1'b1; end
        1: begin
          if (m_arm) begin
            m_arm <= 1'b0; m_idle <= 0;
          end else if (m_timeout()) begin
            m_phase <= 2; m_gap_left <= GAP; m_gap_next <= 3;
          end else begin
            m_idle <= UART_SRAM_we_n ? m_idle + 1 : 0;
          end
        end
        2: begin
          if (m_gap_left == 1) begin
            m_phase <= m_gap_next;
            if (m_gap_next == 1) m_arm <= 1'b1;
          end else begin
            m_gap_left <= m_gap_left - 1;
          end
        end
        3: if (M1_done) begin
          m_phase <= 2; m_gap_left <= GAP;
`ifdef M2_PHASE_EN
          m_gap_next <= 4;
`else
          m_gap_next <= 5;
`endif
        end
`ifdef M2_PHASE_EN
        4: if (M2_done) begin m_phase <= 2; m_gap_left <= GAP; m_gap_next <= 5; end
`endif
        5: if (Start_pulse) begin m_phase <= 2; m_gap_left <= GAP; m_gap_next <= 1; end
        default: m_phase <= 0;
      endcase
    end
  end

  // Mid-cycle compare of every output against the model.
  always @(negedge clk) begin
    check("phase",      {29'd0, Phase},          m_phase);
    check("m1_start",   {31'd0, M1_start},       {31'd0, m_phase == 3});
`ifdef M2_PHASE_EN
    check("m2_start",   {31'd0, M2_start},       {31'd0, m_phase == 4});
`endif
    check("vga_enable", {31'd0, VGA_enable},     {31'd0, m_phase == 5});
    check("rx_enable",  {31'd0, UART_rx_enable}, {31'd0, (m_phase == 1) && !m_timeout()});
    check("rx_init",    {31'd0, UART_rx_initialize}, {31'd0, m_init()});
    check("sram_we_n",  {31'd0, SRAM_we_n},      {31'd0, m_we_n()});
    check("sram_addr",  {14'd0, SRAM_address},   {14'd0, m_addr()});
    check("sram_data",  {16'd0, SRAM_write_data}, {16'd0, m_data()});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gap(input string name);
    int n;
    n = 0;
    while (Phase == 3'd2 && n < 20) begin
      check({name, "_we_n"}, {31'd0, SRAM_we_n}, 32'd1);
      n++;
      tick();
    end
    check({name, "_len"}, n, GAP);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int n;
    repeat (2) tick();
    Resetn = 1'b1;
    repeat (3) tick();
    $display("step 1: idle after reset, cycle %0d", cyc);
    check("rst_we_n",     {31'd0, SRAM_we_n},  32'd1);
    check("rst_m1_start", {31'd0, M1_start},   32'd0);
    check("rst_vga_en",   {31'd0, VGA_enable}, 32'd0);
    check("rst_phase",    {29'd0, Phase},      32'd0);

    // First load: writes to 0..99, then silence until the timeout.
    Start_pulse = 1'b1;
    #1 check("start_init", {31'd0, UART_rx_initialize}, 32'd1);
    tick();
    Start_pulse = 1'b0;
    check("arm_phase",  {29'd0, Phase},          32'd1);
    check("arm_rx_en",  {31'd0, UART_rx_enable}, 32'd1);
    for (int i = 0; i < 100; i++) begin
      UART_SRAM_we_n       = 1'b0;
      UART_SRAM_address    = 18'(i);
      UART_SRAM_write_data = 16'(i * 3 + 16'h100);
      tick();
    end
    e = cyc;
    UART_SRAM_we_n = 1'b1;
    $display("step 2: last UART write sampled at cycle %0d", e);
    while (cyc < e + TIMEOUT - 1) tick();
    check("to_init",   {31'd0, UART_rx_initialize}, 32'd1);
    check("to_rx_en",  {31'd0, UART_rx_enable},     32'd0);
    check("to_phase1", {29'd0, Phase},              32'd1);
    tick();
    check("to_latency", cyc - e, TIMEOUT);
    check("to_phase2",  {29'd0, Phase}, 32'd2);
    tick();
    check("gap1_phase", {29'd0, Phase}, 32'd2);
    tick();
    check("m1_phase",   {29'd0, Phase},    32'd3);
    check("m1_start_hi", {31'd0, M1_start}, 32'd1);

    // Start during M1 is ignored; M1 writes pass through.
    $display("step 3: M1 phase at cycle %0d", cyc);
    Start_pulse = 1'b1;
    #1 check("m1_start_ign_init", {31'd0, UART_rx_initialize}, 32'd0);
    tick();
    Start_pulse = 1'b0;
    check("m1_start_ign_phase", {29'd0, Phase}, 32'd3);
    M1_SRAM_we_n       = 1'b0;
    M1_SRAM_address    = 18'h23EC0;
    M1_SRAM_write_data = 16'hBEEF;
    #1;
    check("m1_we_n",  {31'd0, SRAM_we_n},    32'd0);
    check("m1_addr",  {14'd0, SRAM_address}, 32'h23EC0);
    check("m1_data",  {16'd0, SRAM_write_data}, 32'hBEEF);
    tick();
    M1_done = 1'b1;
    #1 check("m1_done_start", {31'd0, M1_start}, 32'd1);
    tick();
    M1_done = 1'b0;
    check("m1_drop",     {31'd0, M1_start},     32'd0);
    check("gap_hold",    {14'd0, SRAM_address}, 32'h23EC0);
    wait_gap("gap_m1");
`ifdef M2_PHASE_EN
    check("m2_phase", {29'd0, Phase},    32'd4);
    check("m2_start", {31'd0, M2_start}, 32'd1);
    M2_SRAM_we_n    = 1'b0;
    M2_SRAM_address = 18'h01234;
    tick();
    M2_done = 1'b1;
    tick();
    M2_done = 1'b0;
    M2_SRAM_we_n = 1'b1;
    wait_gap("gap_m2");
`endif
    M1_SRAM_we_n = 1'b1;
    check("vga_phase", {29'd0, Phase},      32'd5);
    check("vga_en",    {31'd0, VGA_enable}, 32'd1);
    VGA_SRAM_address = 18'h12345;
    #1;
    check("vga_addr", {14'd0, SRAM_address}, 32'h12345);
    check("vga_we_n", {31'd0, SRAM_we_n},    32'd1);
    tick();
    VGA_SRAM_address = 18'h00777;
    #1 check("vga_addr2", {14'd0, SRAM_address}, 32'h00777);

    // Restart from VGA, then a silent load with address 0.
    $display("step 4: restart from VGA at cycle %0d", cyc);
    UART_SRAM_address = '0;
    Start_pulse = 1'b1;
    #1 check("restart_init", {31'd0, UART_rx_initialize}, 32'd1);
    tick();
    Start_pulse = 1'b0;
    check("restart_gap",    {29'd0, Phase},      32'd2);
    check("restart_vga_en", {31'd0, VGA_enable}, 32'd0);
    repeat (GAP) tick();
    check("restart_phase", {29'd0, Phase},          32'd1);
    check("restart_rx_en", {31'd0, UART_rx_enable}, 32'd1);
    repeat (5000) tick();
    $display("step 5: silent load with address 0, cycle %0d", cyc);
    check("silent_phase", {29'd0, Phase},          32'd1);
    check("silent_rx_en", {31'd0, UART_rx_enable}, 32'd1);

    // One write ends the silent load, then reset mid-M1.
    UART_SRAM_we_n    = 1'b0;
    UART_SRAM_address = 18'd7;
    tick();
    UART_SRAM_we_n = 1'b1;
    n = 0;
    while (Phase != 3'd3 && n < 1500) begin
      tick();
      n++;
    end
    check("reentry_m1", {29'd0, Phase}, 32'd3);
    $display("step 6: reset during M1 at cycle %0d", cyc);
    M1_SRAM_we_n    = 1'b0;
    M1_SRAM_address = 18'h00ABC;
    #1 check("pre_rst_we_n", {31'd0, SRAM_we_n}, 32'd0);
    tick();
    Resetn = 1'b0;
    #1;
    check("rst_mid_we_n",     {31'd0, SRAM_we_n}, 32'd1);
    check("rst_mid_m1_start", {31'd0, M1_start},  32'd0);
    check("rst_mid_phase",    {29'd0, Phase},     32'd0);
    repeat (2) tick();
    Resetn = 1'b1;
    repeat (3) tick();
    check("post_rst_phase", {29'd0, Phase}, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
